// File: rtl/cf_fifo_param.sv
// ---------------------------------------------------------------------------
// cf_fifo_param
//
// Synchronous single-clock FIFO whose outputs come only from registered state.
// Nothing on we, re, clear or wdata reaches an output in the same cycle.
// Occupancy is kept in an explicit counter. The pointers wrap silently.
//
// Handshake semantics:
//   - An enqueue fires when we && !full && !clear.
//   - A dequeue fires when re && !empty && !clear.
//   - full and empty are the registered "ready" indications for the two sides.
//   - A request that arrives while the side is not ready is dropped. It then
//     raises overflow or underflow for one cycle, starting on the next cycle.
//   - clear flushes the FIFO and takes priority over both requests.
//   - The synchronous reset overrides everything, clear included.
//
// Parameters:
//   N        data width in bits
//   DEPTH    number of entries (power of 2, >= 2)
//   AF_LEVEL almost_full asserts when count >= AF_LEVEL
//   AE_LEVEL almost_empty asserts when count <= AE_LEVEL
//
// Ports:
//   clk          clock, rising edge
//   rst_n        synchronous active-low reset
//   we, wdata    enqueue request and its data
//   re           dequeue request
//   clear        synchronous flush
//   rdata        head entry; all-ones while empty
//   full, empty  no free entry / no valid entry
//   count        occupancy, 0..DEPTH
//   almost_full  count >= AF_LEVEL
//   almost_empty count <= AE_LEVEL
//   overflow     one-cycle pulse after a dropped enqueue
//   underflow    one-cycle pulse after a dropped dequeue
// ---------------------------------------------------------------------------
module cf_fifo_param #(
   parameter int N        = 32,
   parameter int DEPTH    = 4,
   parameter int AF_LEVEL = DEPTH - 1,
   parameter int AE_LEVEL = 1
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic                       we,
   input  logic [N-1:0]               wdata,
   input  logic                       re,
   input  logic                       clear,
   output logic [N-1:0]               rdata,
   output logic                       full,
   output logic                       empty,
   output logic [$clog2(DEPTH):0]     count,
   output logic                       almost_full,
   output logic                       almost_empty,
   output logic                       overflow,
   output logic                       underflow
);

   localparam int PW = $clog2(DEPTH);
   localparam int CW = PW + 1;

   localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
   localparam logic [CW-1:0] AF_C    = CW'(AF_LEVEL);
   localparam logic [CW-1:0] AE_C    = CW'(AE_LEVEL);

   logic [N-1:0]  mem [DEPTH];
   logic [PW-1:0] wr_ptr;
   logic [PW-1:0] rd_ptr;
   logic [CW-1:0] cnt;
   logic          ovf_q;
   logic          unf_q;

   logic          full_w;
   logic          empty_w;
   logic          do_enq;
   logic          do_deq;

   // Status flags come from the registered count, never from the requests.
   assign full_w  = (cnt == DEPTH_C);
   assign empty_w = (cnt == '0);

   // The fire conditions look only at the start-of-cycle flags. This is why
   // a write at full stays dropped even when a dequeue fires in the same
   // cycle, and the same holds for a read at empty.
   assign do_enq = we && !full_w  && !clear;
   assign do_deq = re && !empty_w && !clear;

   // Control state
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         cnt    <= '0;
         ovf_q  <= 1'b0;
         unf_q  <= 1'b0;
      end else if (clear) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         cnt    <= '0;
         ovf_q  <= 1'b0;
         unf_q  <= 1'b0;
      end else begin
         if (do_enq) wr_ptr <= wr_ptr + PW'(1);
         if (do_deq) rd_ptr <= rd_ptr + PW'(1);
         case ({do_enq, do_deq})
            2'b10:   cnt <= cnt + CW'(1);
            2'b01:   cnt <= cnt - CW'(1);
            default: cnt <= cnt;
         endcase
         ovf_q <= we && full_w;
         unf_q <= re && empty_w;
      end
   end

   // Storage is not reset. Its contents are qualified by cnt.
   always_ff @(posedge clk) begin
      if (rst_n && do_enq) mem[wr_ptr] <= wdata;
   end

   assign rdata        = empty_w ? {N{1'b1}} : mem[rd_ptr];
   assign full         = full_w;
   assign empty        = empty_w;
   assign count        = cnt;
   assign almost_full  = (cnt >= AF_C);
   assign almost_empty = (cnt <= AE_C);
   assign overflow     = ovf_q;
   assign underflow    = unf_q;

endmodule

// File: tb/tb_cf_fifo_param.sv
// ---------------------------------------------------------------------------
// tb_cf_fifo_param
//
// Directed bench for cf_fifo_param with N=8, DEPTH=4 and the default
// thresholds (AF_LEVEL=3, AE_LEVEL=1). Inputs change 1ns after a rising edge,
// and outputs are checked at that same point.
// ---------------------------------------------------------------------------
module tb_cf_fifo_param;

   localparam int N     = 8;
   localparam int DEPTH = 4;

   logic         clk;
   logic         rst_n;
   logic         we;
   logic [N-1:0] wdata;
   logic         re;
   logic         clear;
   logic [N-1:0] rdata;
   logic         full;
   logic         empty;
   logic [2:0]   count;
   logic         almost_full;
   logic         almost_empty;
   logic         overflow;
   logic         underflow;

   int n_checks;
   int n_pass;

   logic [N-1:0] exp_q[$];

   cf_fifo_param #(.N(N), .DEPTH(DEPTH)) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .we           (we),
      .wdata        (wdata),
      .re           (re),
      .clear        (clear),
      .rdata        (rdata),
      .full         (full),
      .empty        (empty),
      .count        (count),
      .almost_full  (almost_full),
      .almost_empty (almost_empty),
      .overflow     (overflow),
      .underflow    (underflow)
   );

   // clock / reset
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // checker
   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
      n_checks++;
      if (obs === exp_v) n_pass++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp_v);
   endtask

   // driver: apply one cycle of inputs, then return 1ns after the edge
   task automatic cyc(input logic w, input logic [N-1:0] d, input logic r, input logic c);
      we    = w;
      wdata = d;
      re    = r;
      clear = c;
      @(posedge clk);
      #1;
      we    = 1'b0;
      re    = 1'b0;
      clear = 1'b0;
   endtask

   task automatic check_reset_state(input string tag);
      check({tag, "_count"},  32'(count),        32'd0);
      check({tag, "_empty"},  32'(empty),        32'd1);
      check({tag, "_full"},   32'(full),         32'd0);
      check({tag, "_ae"},     32'(almost_empty), 32'd1);
      check({tag, "_af"},     32'(almost_full),  32'd0);
      check({tag, "_ovf"},    32'(overflow),     32'd0);
      check({tag, "_unf"},    32'(underflow),    32'd0);
      check({tag, "_rdata"},  32'(rdata),        32'hFF);
   endtask

   logic [N-1:0] fill_vals [4];
   logic [N-1:0] d;

   initial begin
      n_checks = 0;
      n_pass   = 0;
      rst_n = 1'b0;
      we = 1'b0; re = 1'b0; clear = 1'b0; wdata = '0;
      fill_vals[0] = 8'h11; fill_vals[1] = 8'h22;
      fill_vals[2] = 8'h33; fill_vals[3] = 8'h44;

      // reset
      cyc(1'b0, '0, 1'b0, 1'b0);
      cyc(1'b0, '0, 1'b0, 1'b0);
      rst_n = 1'b1;
      check_reset_state("rst");

      // fill: almost_full from count 3, full at 4, head stays 0x11
      for (int i = 0; i < 4; i++) begin
         cyc(1'b1, fill_vals[i], 1'b0, 1'b0);
         check("fill_count", 32'(count),        32'(i + 1));
         check("fill_af",    32'(almost_full),  32'((i + 1) >= 3));
         check("fill_ae",    32'(almost_empty), 32'((i + 1) <= 1));
         check("fill_full",  32'(full),         32'((i + 1) == 4));
         check("fill_head",  32'(rdata),        32'h11);
      end

      // drain in order
      for (int i = 0; i < 4; i++) begin
         check("drain_rdata", 32'(rdata), 32'(fill_vals[i]));
         cyc(1'b0, '0, 1'b1, 1'b0);
      end
      check("drain_empty", 32'(empty), 32'd1);
      check("drain_rdata_ff", 32'(rdata), 32'hFF);
      check("drain_count", 32'(count), 32'd0);

      // enqueue at full together with a dequeue: 0x55 dropped
      for (int i = 0; i < 4; i++) cyc(1'b1, fill_vals[i], 1'b0, 1'b0);
      check("full_again", 32'(full), 32'd1);
      cyc(1'b1, 8'h55, 1'b1, 1'b0);
      check("ovf_pulse", 32'(overflow), 32'd1);
      check("ovf_count", 32'(count),    32'd3);
      check("ovf_head",  32'(rdata),    32'h22);
      cyc(1'b0, '0, 1'b0, 1'b0);
      check("ovf_clear", 32'(overflow), 32'd0);
      for (int i = 1; i < 4; i++) begin
         check("ovf_drain", 32'(rdata), 32'(fill_vals[i]));
         cyc(1'b0, '0, 1'b1, 1'b0);
      end
      check("ovf_drained_empty", 32'(empty), 32'd1);

      // dequeue at empty together with an enqueue: 0xA5 kept
      cyc(1'b1, 8'hA5, 1'b1, 1'b0);
      check("unf_pulse", 32'(underflow), 32'd1);
      check("unf_count", 32'(count),     32'd1);
      check("unf_rdata", 32'(rdata),     32'hA5);
      cyc(1'b0, '0, 1'b0, 1'b0);
      check("unf_clear", 32'(underflow), 32'd0);
      cyc(1'b0, '0, 1'b1, 1'b0);
      check("unf_drained", 32'(empty), 32'd1);

      // wrap: steady enqueue+dequeue at count 2
      exp_q.delete();
      for (int i = 0; i < 2; i++) begin
         d = N'(i);
         cyc(1'b1, d, 1'b0, 1'b0);
         exp_q.push_back(d);
      end
      check("wrap_start_count", 32'(count), 32'd2);
      for (int i = 0; i < 10; i++) begin
         d = N'(i + 2);
         check("wrap_rdata", 32'(rdata), 32'(exp_q[0]));
         cyc(1'b1, d, 1'b1, 1'b0);
         void'(exp_q.pop_front());
         exp_q.push_back(d);
         check("wrap_count", 32'(count), 32'd2);
      end
      check("wrap_tail_head", 32'(rdata), 32'(exp_q[0]));

      // clear beats a write at count 3
      cyc(1'b1, 8'h0C, 1'b0, 1'b0);
      check("clr_pre_count", 32'(count), 32'd3);
      cyc(1'b1, 8'hEE, 1'b0, 1'b1);
      exp_q.delete();
      check("clr_count", 32'(count),    32'd0);
      check("clr_empty", 32'(empty),    32'd1);
      check("clr_rdata", 32'(rdata),    32'hFF);
      check("clr_ovf",   32'(overflow), 32'd0);
      cyc(1'b0, '0, 1'b0, 1'b0);
      check("clr_write_lost", 32'(count), 32'd0);

      // reset mid-operation, with a write asserted during reset
      cyc(1'b1, 8'h31, 1'b0, 1'b0);
      cyc(1'b1, 8'h32, 1'b0, 1'b0);
      check("mid_pre_count", 32'(count), 32'd2);
      rst_n = 1'b0;
      cyc(1'b1, 8'h99, 1'b0, 1'b0);
      rst_n = 1'b1;
      check_reset_state("mid_rst");
      cyc(1'b1, 8'h77, 1'b0, 1'b0);
      check("post_rst_rdata", 32'(rdata), 32'h77);
      check("post_rst_count", 32'(count), 32'd1);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
